// File: rtl/lights_pkg.sv
// Shared definitions for the 24-bit RGB light bus: field slices, PWM step count
// and the colour-code bit order used by the colour converter and its inverse.
package lights_pkg;
   localparam int CH_W  = 8;
   localparam int R_MSB = 23;
   localparam int G_MSB = 15;
   localparam int B_MSB = 7;

   localparam int PWM_STEPS = 255;
   localparam logic [CH_W-1:0] CNT_LAST = CH_W'(PWM_STEPS - 1);

   // Colour-code bit positions; also used as channel indices inside the driver.
   localparam int CC_R = 2;
   localparam int CC_G = 1;
   localparam int CC_B = 0;
   localparam int NUM_CH = 3;

   typedef logic [CH_W-1:0] chan_t;

   function automatic logic chan_is_exact(input chan_t c);
      return (c == '0) || (c == '1);
   endfunction
endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM colour channel: duty register latched at period boundaries and a
// registered compare against the shared step counter.
module pwm_channel
   import lights_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  i_en,
   input  logic  i_load,
   input  chan_t i_level,
   input  chan_t i_cnt,
   output logic  o_led
);
   chan_t r_duty;
   logic  r_led;

   // The compare uses the pre-edge duty, so a load edge still finishes the old period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_duty <= '0;
         r_led  <= 1'b0;
      end else begin
         if (i_load) r_duty <= i_level;
         r_led <= i_en && (i_cnt < r_duty);
      end
   end

   assign o_led = r_led;
endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: prescaler, 255-step counter, boundary-only light latching
// and the inverse colour-code decoder, feeding three pwm_channel instances.
module rgb_pwm_driver
   import lights_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [23:0] light,
   output logic        led_r,
   output logic        led_g,
   output logic        led_b,
   output logic        period_start,
   output logic [2:0]  colour_code,
   output logic        code_exact
);
   localparam logic [15:0] PRE_LAST = 16'(DIV - 1);

   logic [15:0]              r_pre;
   chan_t                    r_cnt;
   logic                     r_en_d;
   logic                     r_period_start;
   logic [2:0]               r_code;
   logic                     r_exact;
   logic [NUM_CH-1:0][CH_W-1:0] w_level;
   logic [NUM_CH-1:0]        w_led;
   logic [2:0]               w_code;
   logic                     w_exact;
   logic                     w_tick;
   logic                     w_load;

   assign w_level[CC_R] = light[R_MSB -: CH_W];
   assign w_level[CC_G] = light[G_MSB -: CH_W];
   assign w_level[CC_B] = light[B_MSB -: CH_W];

   assign w_tick = (r_pre == PRE_LAST);
   // A fresh enable always reloads, so a disabled wrap can never latch anything.
   assign w_load = enable && (!r_en_d || (w_tick && (r_cnt == CNT_LAST)));

   always_comb begin
      w_code  = '0;
      w_exact = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         w_code[i] = |w_level[i];
         w_exact   = w_exact && chan_is_exact(w_level[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre          <= '0;
         r_cnt          <= '0;
         r_en_d         <= 1'b0;
         r_period_start <= 1'b0;
         r_code         <= '0;
         r_exact        <= 1'b0;
      end else if (!enable) begin
         r_pre          <= '0;
         r_cnt          <= '0;
         r_en_d         <= 1'b0;
         r_period_start <= 1'b0;
      end else begin
         r_en_d         <= 1'b1;
         r_period_start <= w_load;
         if (w_load) begin
            r_pre   <= '0;
            r_cnt   <= '0;
            r_code  <= w_code;
            r_exact <= w_exact;
         end else if (w_tick) begin
            r_pre <= '0;
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_pre <= r_pre + 16'd1;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pwm_channel u_ch (
         .clk     (clk),
         .rst     (rst),
         .i_en    (enable),
         .i_load  (w_load),
         .i_level (w_level[gi]),
         .i_cnt   (r_cnt),
         .o_led   (w_led[gi])
      );
   end

   assign led_r        = w_led[CC_R];
   assign led_g        = w_led[CC_G];
   assign led_b        = w_led[CC_B];
   assign period_start = r_period_start;
   assign colour_code  = r_code;
   assign code_exact   = r_exact;
endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Consumer end of the 24-bit RGB light bus produced by the lights selector.
- Converts the light word into three PWM LED drive pins for the board's RGB LED.
- Decodes the word back to a 3-bit colour code, the inverse of the colour converter.
- The light word is latched only at PWM period boundaries, so mid-period changes never glitch a duty cycle.

Parameters:
- DIV, 4, clocks per PWM step (legal 1..65535); prescaler width is 16 bits.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high; one clock domain only.
- enable  in  1  1 = run PWM; 0 = outputs off, counters held.
- light  in  24  RGB word: [23:16] R, [15:8] G, [7:0] B.
- led_r  out  1  PWM drive, red.
- led_g  out  1  PWM drive, green.
- led_b  out  1  PWM drive, blue.
- period_start  out  1  one-clk pulse when a new period begins and the light word is latched.
- colour_code  out  3  {R!=0, G!=0, B!=0} of the latched word.
- code_exact  out  1  1 when every latched channel is exactly 8'h00 or 8'hFF.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - pre=0, cnt=0, duty_r/g/b=0.
  - led_r/g/b=0, period_start=0, colour_code=3'b000, code_exact=0.
- Prescaler: pre counts 0..DIV-1. tick=1 when pre==DIV-1. With DIV=1, tick=1 every clk.
- Step counter cnt (8 bit):
  - Advances on tick, counting 0..254, so 255 steps per period.
  - 254 wraps to 0. cnt never reaches 255.
  - Period = 255*DIV clks.
- Period boundary (load): occurs on the edge where cnt wraps 254->0, and on the first edge with enable=1 after enable=0 or reset.
  - On that edge: duty_r/g/b <= light fields; colour_code and code_exact are updated from the same light value.
  - period_start=1 for exactly that one clk, else 0.
- Light sampling: light is sampled only at the load edge. Changes at any other time are ignored until the next boundary.
- LED outputs are registered: led_x <= (cnt < duty_x), using pre-edge values. LEDs therefore lag cnt by one clk.
  - duty 8'h00: LED never high.
  - duty 8'hFF: LED always high, because cnt <= 254.
  - duty N: LED high for N of 255 steps.
- Disable path: enable=0 at an edge sets pre=0, cnt=0, led_r/g/b=0 and period_start=0.
  - duty, colour_code and code_exact hold their values.
- Re-enable: enable 0->1 forces a fresh load and restarts from cnt=0, pre=0. It never resumes a partial period.
- Simultaneous events:
  - rst dominates everything.
  - enable=0 dominates a wrap occurring on the same edge; no load happens.
- Reset mid-period: all state clears immediately, with no completion of the current period.

Decomposition:
- Shared package (lights_pkg):
  - Light field slice constants R_MSB=23, G_MSB=15, B_MSB=7, CH_W=8.
  - PWM_STEPS=255.
  - Colour code bit order constants, shared with the colour converter.
- One natural sub-module: pwm_channel. It holds one duty register, the compare, and the registered LED output, and is instantiated three times.
- Prescaler, step counter, load control and the decoder stay in the top.

Test Plan:
- Reset: rst=1 mid-run with light=24'hFF8000 -> all outputs 0 immediately (asynchronous). After release with enable=1, first period_start on the next edge.
- Duty accuracy, DIV=1: light=24'hFF8000 -> per 255-clk period, led_r high 255, led_g high 128, led_b high 0. colour_code=3'b110, code_exact=0.
- Boundary latch: change light from 24'h0000FF to 24'hFFFFFF at cnt=100 -> led_b unchanged until the next period_start. Next period: all LEDs high, colour_code=3'b111, code_exact=1.
- Prescale: DIV=4, light=24'h010000 -> led_r high for exactly 4 clks per 1020-clk period. period_start spacing is 1020 clks.
- Enable: drop enable for 10 clks mid-period -> LEDs 0 from the next edge and colour_code held. Re-enable -> period_start on the first enabled edge, cnt restarts from 0.
- Simultaneous: enable=0 on the wrap edge -> no period_start, duty unchanged.
